// File: rtl/wb_arbiter_pkg.sv
// Shared execute-stage definitions: register selects, the PC register index and NZCV flags.
package wb_arbiter_pkg;

    typedef logic [3:0] reg_sel_t;

    localparam reg_sel_t REG_PC = 4'd15;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-producer scoreboard for r0..r14: set on issue, clear on write-back, hazard lookup.
module wb_scoreboard
    import wb_arbiter_pkg::*;
(
    input  logic     clock,
    input  logic     not_reset,
    input  logic     issue_valid,
    input  reg_sel_t issue_rd,
    output logic     issue_stall,
    input  logic     clr_valid,
    input  reg_sel_t clr_rd,
    input  reg_sel_t sel_p0,
    input  reg_sel_t sel_p1,
    output logic     hazard_p0,
    output logic     hazard_p1
);

    logic [14:0] pending_q, pending_d;
    logic [15:0] pending_ext;
    logic [15:0] next_ext;
    logic        issue_take;

    // r15 slot is tied low so lookups of the PC never report pending
    assign pending_ext = {1'b0, pending_q};

    assign issue_stall = issue_valid && pending_ext[issue_rd];
    assign issue_take  = issue_valid && !issue_stall && (issue_rd != REG_PC);
    assign hazard_p0   = pending_ext[sel_p0];
    assign hazard_p1   = pending_ext[sel_p1];

    always_comb begin
        next_ext = pending_ext;
        if (clr_valid) begin
            next_ext[clr_rd] = 1'b0;
        end
        if (issue_take) begin
            next_ext[issue_rd] = 1'b1;
        end
        pending_d = next_ext[14:0];
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares the register-file write port between ALU and load returns,
// keeps the authoritative flags shadow and fronts the pending-register scoreboard.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clock,
    input  logic        not_reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [3:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        alu_flag_we,
    input  logic [3:0]  alu_flags,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [3:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        wr_not_enable,
    output logic [3:0]  wr_sel,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_flags,
    input  logic        issue_valid,
    input  logic [3:0]  issue_rd,
    output logic        issue_stall,
    input  logic [3:0]  sel_p0,
    input  logic [3:0]  sel_p1,
    output logic        hazard_p0,
    output logic        hazard_p1,
    output logic        bad_rd
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0]  starve_q, starve_d;
    nzcv_t       shadow_q, shadow_d;
    logic        wr_ne_q, wr_ne_d;
    reg_sel_t    wr_sel_q, wr_sel_d;
    logic [31:0] wr_data_q, wr_data_d;
    nzcv_t       wr_flags_q, wr_flags_d;
    logic        bad_rd_q, bad_rd_d;

    logic     force_alu;
    logic     alu_xfer;
    logic     ld_xfer;
    logic     xfer;
    reg_sel_t xfer_rd;

    // Readies depend only on the other side's valid and internal state
    assign force_alu = alu_valid && (starve_q == STARVE_MAX);
    assign ld_ready  = !force_alu;
    assign alu_ready = !ld_valid || force_alu;
    assign alu_xfer  = alu_valid && alu_ready;
    assign ld_xfer   = ld_valid && ld_ready;
    assign xfer      = alu_xfer || ld_xfer;
    assign xfer_rd   = alu_xfer ? alu_rd : ld_rd;

    always_comb begin
        starve_d = starve_q;
        if (alu_valid && ld_xfer) begin
            if (starve_q != STARVE_MAX) begin
                starve_d = starve_q + 4'd1;
            end
        end else if (alu_xfer || !alu_valid) begin
            starve_d = '0;
        end
    end

    always_comb begin
        shadow_d   = shadow_q;
        wr_ne_d    = 1'b1;
        wr_sel_d   = wr_sel_q;
        wr_data_d  = wr_data_q;
        wr_flags_d = wr_flags_q;
        bad_rd_d   = 1'b0;
        if (alu_xfer && alu_flag_we) begin
            shadow_d = nzcv_t'(alu_flags);
        end
        if (xfer) begin
            wr_sel_d   = xfer_rd;
            wr_data_d  = alu_xfer ? alu_data : ld_data;
            // Always present the flags as they stand after this write
            wr_flags_d = shadow_d;
            wr_ne_d    = (xfer_rd == REG_PC);
            bad_rd_d   = (xfer_rd == REG_PC);
        end
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            starve_q   <= '0;
            shadow_q   <= '0;
            wr_ne_q    <= 1'b1;
            wr_sel_q   <= '0;
            wr_data_q  <= '0;
            wr_flags_q <= '0;
            bad_rd_q   <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            shadow_q   <= shadow_d;
            wr_ne_q    <= wr_ne_d;
            wr_sel_q   <= wr_sel_d;
            wr_data_q  <= wr_data_d;
            wr_flags_q <= wr_flags_d;
            bad_rd_q   <= bad_rd_d;
        end
    end

    assign wr_not_enable = wr_ne_q;
    assign wr_sel        = wr_sel_q;
    assign wr_data       = wr_data_q;
    assign wr_flags      = wr_flags_q;
    assign bad_rd        = bad_rd_q;

    wb_scoreboard u_scoreboard (
        .clock       (clock),
        .not_reset   (not_reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_stall (issue_stall),
        .clr_valid   (xfer),
        .clr_rd      (xfer_rd),
        .sel_p0      (sel_p0),
        .sel_p1      (sel_p1),
        .hazard_p0   (hazard_p0),
        .hazard_p1   (hazard_p1)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a reference model predicts write-port traffic into a queue
// that a negedge monitor drains; readies, stalls and hazards are checked against the model.
module tb_wb_arbiter;

    localparam int LIMIT = 3;

    logic        clock = 1'b0;
    logic        not_reset;
    logic        alu_valid, alu_ready, alu_flag_we;
    logic [3:0]  alu_rd, alu_flags;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [3:0]  ld_rd;
    logic [31:0] ld_data;
    logic        wr_not_enable;
    logic [3:0]  wr_sel, wr_flags;
    logic [31:0] wr_data;
    logic        issue_valid, issue_stall;
    logic [3:0]  issue_rd, sel_p0, sel_p1;
    logic        hazard_p0, hazard_p1, bad_rd;

    wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock         (clock),
        .not_reset     (not_reset),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_flag_we   (alu_flag_we),
        .alu_flags     (alu_flags),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .wr_not_enable (wr_not_enable),
        .wr_sel        (wr_sel),
        .wr_data       (wr_data),
        .wr_flags      (wr_flags),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_stall   (issue_stall),
        .sel_p0        (sel_p0),
        .sel_p1        (sel_p1),
        .hazard_p0     (hazard_p0),
        .hazard_p1     (hazard_p1),
        .bad_rd        (bad_rd)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
        logic [3:0]  flags;
        bit          pc;
    } wr_t;

    wr_t exp_q[$];
    wr_t last_wr;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    // Reference model state
    bit         pend[16];
    logic [3:0] m_shadow;
    int         lost_run;

    logic obs_alu_ready, obs_stall, obs_haz0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) pend[i] = 1'b0;
        m_shadow = 4'd0;
        lost_run = 0;
        last_wr  = '{rd: 4'd0, data: 32'd0, flags: 4'd0, pc: 1'b0};
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd      = 4'd0;
        alu_data    = 32'd0;
        alu_flag_we = 1'b0;
        alu_flags   = 4'd0;
        ld_valid    = 1'b0;
        ld_rd       = 4'd0;
        ld_data     = 32'd0;
        issue_valid = 1'b0;
        issue_rd    = 4'd0;
        sel_p0      = 4'd0;
        sel_p1      = 4'd0;
    endtask

    // One clock: check combinational outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit alu_forced, alu_win, ld_win, stall;
        wr_t e;
        @(negedge clock);
        // ALU has lost LIMIT times in a row while waiting: it must win now
        alu_forced = alu_valid && (lost_run >= LIMIT);
        stall      = issue_valid && pend[issue_rd];
        chk("alu_ready", alu_ready, !ld_valid || alu_forced);
        chk("ld_ready", ld_ready, !alu_forced);
        chk("issue_stall", issue_stall, stall);
        chk("hazard_p0", hazard_p0, pend[sel_p0]);
        chk("hazard_p1", hazard_p1, pend[sel_p1]);
        obs_alu_ready = alu_ready;
        obs_stall     = issue_stall;
        obs_haz0      = hazard_p0;
        @(posedge clock);
        alu_win = alu_valid && (!ld_valid || alu_forced);
        ld_win  = ld_valid && !alu_win;
        if (alu_valid && ld_win) lost_run++;
        else lost_run = 0;
        if (alu_win || ld_win) begin
            e.rd   = alu_win ? alu_rd : ld_rd;
            e.data = alu_win ? alu_data : ld_data;
            if (alu_win && alu_flag_we) m_shadow = alu_flags;
            e.flags = m_shadow;
            e.pc    = (e.rd == 4'd15);
            exp_q.push_back(e);
            pend[e.rd] = 1'b0;
        end
        if (issue_valid && !stall && issue_rd != 4'd15) pend[issue_rd] = 1'b1;
        pend[15] = 1'b0;
        #1;
    endtask

    always @(negedge clock) begin
        wr_t e;
        if (mon_en) begin
            if (!wr_not_enable || bad_rd) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_write: got sel %0h data %0h, expected no write",
                             wr_sel, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_sel", wr_sel, e.rd);
                    chk("wr_data", wr_data, e.data);
                    chk("wr_flags", wr_flags, e.flags);
                    chk("wr_not_enable", wr_not_enable, e.pc);
                    chk("bad_rd", bad_rd, e.pc);
                    last_wr = e;
                end
            end else begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_write: got none, expected sel %0h data %0h",
                             e.rd, e.data);
                    last_wr = e;
                end else begin
                    chk("hold_sel", wr_sel, last_wr.rd);
                    chk("hold_data", wr_data, last_wr.data);
                    chk("hold_flags", wr_flags, last_wr.flags);
                end
            end
        end
    end

    initial begin
        bit seq[4];
        idle_inputs();
        model_reset();
        not_reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_wr_ne", wr_not_enable, 1);
        chk("rst_wr_sel", wr_sel, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_flags", wr_flags, 0);
        chk("rst_bad_rd", bad_rd, 0);
        not_reset = 1'b1;
        mon_en    = 1'b1;

        // ALU only, flags written
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 32'hDEADBEEF;
        alu_flag_we = 1'b1; alu_flags = 4'b1000;
        cycle();
        chk("t_alu_ready", obs_alu_ready, 1);
        chk("t_alu_sel", wr_sel, 3);
        chk("t_alu_data", wr_data, 32'hDEADBEEF);
        chk("t_alu_flags", wr_flags, 4'b1000);
        chk("t_alu_we", wr_not_enable, 0);

        // ALU write without flags keeps the shadow
        alu_rd = 4'd4; alu_data = 32'h12345678; alu_flag_we = 1'b0; alu_flags = 4'b0101;
        cycle();
        chk("t_flag_keep", wr_flags, 4'b1000);

        // Contention: load wins LIMIT times, then the ALU
        alu_valid = 1'b1; alu_rd = 4'd1; ld_valid = 1'b1; ld_rd = 4'd2; ld_data = 32'h0BADF00D;
        for (int i = 0; i < 4; i++) begin
            alu_data = 32'hA000_0000 + i;
            cycle();
            seq[i] = obs_alu_ready;
        end
        chk("t_contend_seq", {seq[0], seq[1], seq[2], seq[3]}, 4'b0001);
        cycle();
        chk("t_contend_after", obs_alu_ready, 0);
        idle_inputs();
        cycle();

        // Scoreboard: issue, WAW stall, clear by load
        issue_valid = 1'b1; issue_rd = 4'd5;
        cycle();
        sel_p0 = 4'd5;
        cycle();
        chk("t_waw_stall", obs_stall, 1);
        chk("t_haz_set", obs_haz0, 1);
        issue_valid = 1'b0; ld_valid = 1'b1; ld_rd = 4'd5; ld_data = 32'h55;
        cycle();
        chk("t_haz_clear", hazard_p0, 0);
        idle_inputs();

        // r15 write: handshake, no write, flags still captured
        alu_valid = 1'b1; alu_rd = 4'd15; alu_flag_we = 1'b1; alu_flags = 4'b0110;
        alu_data = 32'hF00D;
        cycle();
        chk("t_pc_ne", wr_not_enable, 1);
        chk("t_pc_bad", bad_rd, 1);
        alu_rd = 4'd2; alu_flag_we = 1'b0; alu_flags = 4'b1111; alu_data = 32'h22;
        cycle();
        chk("t_pc_pulse", bad_rd, 0);
        chk("t_pc_flags", wr_flags, 4'b0110);
        idle_inputs();

        // Reset in the middle of a transfer
        alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 32'h7777; alu_flag_we = 1'b1;
        alu_flags = 4'b0011; issue_valid = 1'b1; issue_rd = 4'd9; sel_p0 = 4'd9;
        cycle();
        mon_en    = 1'b0;
        not_reset = 1'b0;
        #1;
        chk("t_rst_ne", wr_not_enable, 1);
        chk("t_rst_sel", wr_sel, 0);
        chk("t_rst_data", wr_data, 0);
        chk("t_rst_flags", wr_flags, 0);
        chk("t_rst_pend", hazard_p0, 0);
        idle_inputs();
        model_reset();
        @(posedge clock);
        #1;
        not_reset = 1'b1;
        mon_en    = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            alu_valid   = ($urandom_range(0, 99) < 60);
            alu_rd      = 4'($urandom_range(0, 15));
            alu_data    = $urandom;
            alu_flag_we = 1'($urandom_range(0, 1));
            alu_flags   = 4'($urandom_range(0, 15));
            ld_valid    = ($urandom_range(0, 99) < 55);
            ld_rd       = 4'($urandom_range(0, 15));
            ld_data     = $urandom;
            issue_valid = ($urandom_range(0, 99) < 40);
            issue_rd    = 4'($urandom_range(0, 15));
            sel_p0      = 4'($urandom_range(0, 15));
            sel_p1      = 4'($urandom_range(0, 15));
            cycle();
        end
        idle_inputs();
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and register scoreboard for the execute stage's register file. It shares the file's single write port (register plus flags, written on the falling clock edge) between the ALU result path and the load-return path. It keeps an authoritative shadow of the flags, so writes that do not update flags preserve them. It also tracks registers with an outstanding producer, and raises read and issue hazards so the sequencer stalls instead of reading stale data.

## Interface
Parameters:
- STARVE_LIMIT, 3, consecutive lost ALU contention cycles before the ALU is granted once over the load path (1..15).

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- not_reset  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- alu_rd  in  4  ALU destination register
- alu_data  in  32  ALU result
- alu_flag_we  in  1  ALU result also updates flags
- alu_flags  in  4  new NZCV flags
- ld_valid  in  1  load data offered
- ld_ready  out  1  load data accepted this cycle (combinational)
- ld_rd  in  4  load destination register
- ld_data  in  32  load data
- wr_not_enable  out  1  register-file write disable; 1 means no write
- wr_sel  out  4  register-file write select
- wr_data  out  32  register-file write data
- wr_flags  out  4  register-file flags input
- issue_valid  in  1  sequencer issues an instruction that has a register destination
- issue_rd  in  4  destination of the issued instruction
- issue_stall  out  1  issue_rd is already pending; the issue is not taken (combinational)
- sel_p0, sel_p1  in  4  read selects being presented to the register file
- hazard_p0, hazard_p1  out  1  the selected register is pending (combinational)
- bad_rd  out  1  one-cycle pulse: an accepted write targeted r15

## Operation
- Arbitration:
  - force_alu = alu_valid && starve_cnt == STARVE_LIMIT.
  - ld_ready = !force_alu.
  - alu_ready = !ld_valid || force_alu.
  - A transfer happens when valid && ready; at most one transfer per cycle.
- Starvation counter:
  - starve_cnt increments when alu_valid && ld_valid && the load is granted.
  - It clears when the ALU is granted or when alu_valid = 0.
  - It saturates at STARVE_LIMIT.
  - Width is 4 bits.
- Write port:
  - On a transfer, the outputs register wr_sel = rd, wr_data = data, wr_not_enable = 0.
  - With no transfer, wr_not_enable = 1 and wr_sel, wr_data and wr_flags hold their values.
- Flags:
  - The shadow_flags register is updated only by an ALU transfer with alu_flag_we = 1.
  - wr_flags always presents the flags value valid after the current write: the new alu_flags when flags are being written, otherwise shadow_flags.
  - The register file therefore never receives stale flags.
- r15 (PC, held outside the file):
  - A transfer with rd = 15 completes its handshake.
  - wr_not_enable stays 1 and bad_rd pulses.
  - Flags are still updated when alu_flag_we = 1.
- Scoreboard: 15-bit pending vector, r0..r14.
  - Set: issue_valid && !issue_stall && issue_rd != 15 sets pending[issue_rd].
  - Clear: a transfer clears pending[rd], including a transfer for a non-pending register, which is harmless.
  - issue_stall = issue_valid && pending[issue_rd]; WAW issues stall.
  - A set and a clear of the same register in one cycle cannot occur (the issue is stalled while pending). If a set and a clear hit different registers, both apply.
- Hazards:
  - hazard_pX = pending[sel_pX]; it is 0 for sel = 15.
  - Hazards read the current pending state, so a register being cleared this cycle is still reported hazardous.

## Timing
- Reset (async, not_reset = 0):
  - wr_not_enable = 1; wr_sel, wr_data, wr_flags = 0.
  - shadow_flags = 0, pending = 0, starve_cnt = 0, bad_rd = 0.
- Reset mid-write: the write-port outputs drop to idle immediately and the register file sees no write.
- Transfer at rising edge N: write outputs are stable from edge N, and the register file commits at the falling edge of cycle N.
- Pending clears at edge N. hazard and issue_stall are low from edge N onward.
- Issue latency: pending is set at the edge where the issue is taken. hazard reflects it from that edge onward.
- Ready outputs depend only on the other requester's valid plus internal state, so there is no combinational loop through a requester.

## Structure
- Shared execute package: the REG_PC = 4'd15 constant, the NZCV flags typedef, and a 4-bit reg_sel_t.
- One sub-module: wb_scoreboard, holding the pending vector, set/clear, and hazard/issue_stall logic. Arbitration and flags live in the top.

## Test plan
- ALU only: alu_valid, rd = 3, data = 0xDEADBEEF, flag_we = 1, flags = 4'b1000 -> alu_ready = 1, next cycle wr_sel = 3, wr_data = 0xDEADBEEF, wr_flags = 1000, wr_not_enable = 0.
- Flag preservation: ALU write with flag_we = 0 following the case above -> wr_flags = 1000.
- Contention, STARVE_LIMIT = 3: both valid continuously -> load granted 3 cycles, ALU on the 4th, starve_cnt = 0 afterwards.
- Scoreboard: issue rd = 5 -> hazard_p0 = 1 with sel_p0 = 5; a second issue of rd = 5 -> issue_stall = 1; load write to rd = 5 -> hazard clears that edge.
- r15: ALU rd = 15, flag_we = 1, flags = 0110 -> handshake completes, wr_not_enable = 1, bad_rd pulses once, the next write carries flags 0110.
- Reset mid-stream: assert not_reset = 0 during a transfer -> all outputs at reset values immediately, pending = 0.
